// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Provides the FSM state encoding, the default operand width and a
// magnitude helper that widens by one bit so |most-negative| fits.
package div_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  // Widest operand supported by abs_mag, plus the extra magnitude bit
  localparam int unsigned MAG_W     = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Magnitude of a width-bit two's complement value, returned in width+1 bits
  function automatic logic [MAG_W-1:0] abs_mag(input logic [MAG_W-2:0] value,
                                               input int unsigned      width);
    logic [MAG_W-1:0] ext;
    logic [MAG_W-1:0] mask;
    logic             sign;
    sign = value[5'(width - 1)];
    ext  = '0;
    for (int unsigned i = 0; i < MAG_W - 1; i++) begin
      ext[6'(i)] = (i < width) ? value[5'(i)] : sign;
    end
    ext[MAG_W-1] = sign;
    if (sign) begin
      ext = ~ext + MAG_W'(1);
    end
    mask = (MAG_W'(1) << (width + 1)) - MAG_W'(1);
    return ext & mask;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
//   a_in/q_in : partial remainder and quotient/dividend shift register
//   m_in      : divisor magnitude (WIDTH+1 bits)
//   a_out_c/q_out_c : combinational next partial remainder and quotient
// The partial remainder always stays below m_in, so WIDTH bits hold it and
// the shifted value fits in WIDTH+1 bits.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH:0]   m_in,
  output logic [WIDTH-1:0] a_out_c,
  output logic [WIDTH-1:0] q_out_c
);

  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] diff;

  // Shift {A,Q} left, trial-subtract M, keep the difference only if non-negative
  always_comb begin
    a_sh = {a_in, q_in[WIDTH-1]};
    diff = a_sh - m_in;
    if (diff[WIDTH]) begin
      a_out_c = a_sh[WIDTH-1:0];
      q_out_c = {q_in[WIDTH-2:0], 1'b0};
    end else begin
      a_out_c = diff[WIDTH-1:0];
      q_out_c = {q_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient
// bit per clock, sign correction on entry to DONE.
//   clk, reset (async, active-low)
//   start            : level request, sampled in IDLE
//   dividend/divisor : signed operands, latched on accept
//   quotient/remainder : signed results, held until the next accept
//   done, busy, div_by_zero, overflow : status
//   count            : iteration index in progress
module booth_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   m_reg;
  logic             sd;
  logic             sv;

  logic [WIDTH:0]   div_mag;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] a_step;
  logic [WIDTH-1:0] q_step;

  // Operand magnitudes; |most-negative| needs the full unsigned WIDTH bits
  always_comb begin
    div_mag = (WIDTH+1)'(abs_mag((MAG_W-1)'(divisor), WIDTH));
    dvd_mag = WIDTH'(abs_mag((MAG_W-1)'(dividend), WIDTH));
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .a_in    (a_reg),
    .q_in    (q_reg),
    .m_in    (m_reg),
    .a_out_c (a_step),
    .q_out_c (q_step)
  );

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      sd          <= 1'b0;
      sv          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      count       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sd          <= dividend[WIDTH-1];
            sv          <= divisor[WIDTH-1];
            m_reg       <= div_mag;
            q_reg       <= dvd_mag;
            a_reg       <= '0;
            count       <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= ST_DONE;
            end else begin
              busy  <= 1'b1;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          a_reg <= a_step;
          q_reg <= q_step;
          if (count == LAST) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= (sd ^ sv) ? -q_step : q_step;
            remainder <= sd ? -a_step : a_step;
            // A positive result with the top magnitude bit set cannot be represented
            overflow  <= ~(sd ^ sv) & q_step[WIDTH-1];
          end else begin
            count <= count + CW'(1);
          end
        end
        ST_DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider (WIDTH=4): directed table, random
// operands against an integer-arithmetic reference, hold/pulse handshakes
// and an asynchronous reset in the middle of a calculation.
module tb_booth_divider;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          done;
  logic          busy;
  logic          div_by_zero;
  logic          overflow;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } vec_t;

  vec_t vecs[14];

  booth_divider #(.WIDTH(W), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed integer division, truncating toward zero
  function automatic void model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                output logic [W-1:0] eq, output logic [W-1:0] er,
                                output logic edz, output logic eov);
    int a;
    int b;
    a   = int'($signed(dd));
    b   = int'($signed(dv));
    edz = 1'b0;
    eov = 1'b0;
    if (b == 0) begin
      eq  = '1;
      er  = dd;
      edz = 1'b1;
    end else if (a == -(2 ** (W - 1)) && b == -1) begin
      eq  = W'(a);
      er  = '0;
      eov = 1'b1;
    end else begin
      eq = W'(a / b);
      er = W'(a % b);
    end
  endfunction

  // One full division with handshake, latency, status and hold checks
  task automatic run_div(input string tag, input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic eov, input bit hold);
    int lat;
    int busy_err;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    if (!hold) start = 1'b0;
    lat      = 1;
    busy_err = 0;
    @(negedge clk);
    while (!done && lat < 20) begin
      if (busy !== 1'b1) busy_err++;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), (dv == '0) ? 32'd1 : 32'(W + 1));
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " quotient"}, 32'(quotient), 32'(eq));
    chk({tag, " remainder"}, 32'(remainder), 32'(er));
    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
    chk({tag, " overflow"}, 32'(overflow), 32'(eov));
    chk({tag, " busy at done"}, 32'(busy), 32'd0);
    chk({tag, " busy during calc"}, 32'(busy_err), 32'd0);
    chk({tag, " count"}, 32'(count), (dv == '0) ? 32'd0 : 32'(W - 1));
    if (hold) begin
      repeat (2) @(negedge clk);
      chk({tag, " done held"}, 32'(done), 32'd1);
      chk({tag, " quotient held"}, 32'(quotient), 32'(eq));
      start = 1'b0;
    end
    @(negedge clk);
    chk({tag, " done cleared"}, 32'(done), 32'd0);
    chk({tag, " idle result"}, 32'({quotient, remainder, div_by_zero, overflow}),
        32'({eq, er, edz, eov}));
  endtask

  initial begin
    logic [W-1:0] rdd;
    logic [W-1:0] rdv;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    logic         eov;
    int           n;

    vecs[0]  = '{4'd7,  4'd2,  4'd3,  4'd1,  1'b0, 1'b0};
    vecs[1]  = '{4'h9,  4'd2,  4'hD,  4'hF,  1'b0, 1'b0};
    vecs[2]  = '{4'd7,  4'hE,  4'hD,  4'd1,  1'b0, 1'b0};
    vecs[3]  = '{4'h8,  4'hF,  4'h8,  4'd0,  1'b0, 1'b1};
    vecs[4]  = '{4'h8,  4'd5,  4'hF,  4'hD,  1'b0, 1'b0};
    vecs[5]  = '{4'd5,  4'd0,  4'hF,  4'd5,  1'b1, 1'b0};
    vecs[6]  = '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0, 1'b0};
    vecs[7]  = '{4'd5,  4'd5,  4'd1,  4'd0,  1'b0, 1'b0};
    vecs[8]  = '{4'd6,  4'd3,  4'd2,  4'd0,  1'b0, 1'b0};
    vecs[9]  = '{4'hF,  4'h8,  4'd0,  4'hF,  1'b0, 1'b0};
    vecs[10] = '{4'd7,  4'h8,  4'd0,  4'd7,  1'b0, 1'b0};
    vecs[11] = '{4'h8,  4'd1,  4'h8,  4'd0,  1'b0, 1'b0};
    vecs[12] = '{4'h8,  4'h8,  4'd1,  4'd0,  1'b0, 1'b0};
    vecs[13] = '{4'h8,  4'd0,  4'hF,  4'h8,  1'b1, 1'b0};

    clk      = 1'b0;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("reset state", 32'({quotient, remainder, count, done, busy, div_by_zero, overflow}), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table, alternating held and pulsed start
    for (int i = 0; i < 14; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r,
              vecs[i].dz, vecs[i].ov, (i % 2) == 0);
    end

    // Random operands against the reference
    for (int i = 0; i < 40; i++) begin
      rdd = W'($urandom);
      rdv = W'($urandom);
      model(rdd, rdv, eq, er, edz, eov);
      run_div($sformatf("rand%0d %0h/%0h", i, rdd, rdv), rdd, rdv, eq, er, edz, eov,
              ($urandom % 2) == 0);
    end

    // Asynchronous reset in the middle of a calculation
    @(negedge clk);
    dividend = 4'd7;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    @(negedge clk);
    while (count != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid-calc busy", 32'(busy), 32'd1);
    chk("mid-calc count", 32'(count), 32'd2);
    reset = 1'b0;
    #1;
    chk("async reset outputs", 32'({quotient, remainder, count, done, busy, div_by_zero, overflow}),
        32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post-reset idle", 32'({done, busy}), 32'd0);
    run_div("after reset 6/3", 4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
